trig_sequencer: RTL and testbench
=================================

Name: trig_sequencer

Overview:
Trigger scheduler between the external trigger pin and the imager frame-capture logic. Selects the trigger source: external pin, internal periodic timer, or external with automatic internal fallback when the pin goes quiet. It enforces one frame in flight plus a configurable holdoff, issues single-cycle trigger pulses, and counts issued and dropped triggers.

Parameters:
PERIOD_W, 26, width of cfg_period and cfg_timeout counters
HOLD_W, 16, width of cfg_holdoff counter
CNT_W, 16, width of trig_cnt and missed_cnt

Ports:
sys_clk_i  in  1  system clock; all logic is on its rising edge
sys_rst_i  in  1  asynchronous active-high reset
EXT_TRIG_B  in  1  external trigger, active low, asynchronous to sys_clk_i
cfg_mode  in  2  0=off, 1=internal, 2=external, 3=external with fallback
cfg_period  in  PERIOD_W  internal trigger period in cycles; 0 disables internal events
cfg_holdoff  in  HOLD_W  cycles to wait after frame_done before re-arming
cfg_timeout  in  PERIOD_W  quiet-pin cycles before fallback (mode 3)
frame_done  in  1  one-cycle pulse from capture logic, frame finished
cnt_clr  in  1  synchronous clear of trig_cnt and missed_cnt
trig_o  out  1  one-cycle trigger pulse to capture logic
trig_src  out  1  source of the last trig_o: 0=external, 1=internal
busy  out  1  high in BUSY and HOLDOFF
fallback  out  1  high while mode 3 runs from the internal timer
trig_cnt  out  CNT_W  triggers issued, saturating
missed_cnt  out  CNT_W  events dropped, saturating

Behaviour:
- Reset, asynchronous: all outputs 0, FSM=IDLE, sync flops=1, internal timer loaded with cfg_period-1, timeout counter loaded with cfg_timeout.
- External path: 2-flop synchronizer plus one delay flop. ext_evt = delayed & ~sync, i.e. a falling edge. EXT_TRIG_B first sampled low at edge k -> trig_o high after edge k+3 if FSM is in WAIT. A held-low level produces one event only.
- Internal timer: runs when the effective source is internal (mode 1, or mode 3 with fallback=1). It decrements each cycle. At 0 it raises int_evt for one cycle and reloads cfg_period-1. With cfg_period=0 it never fires. The timer reloads on entry to internal operation.
- Effective event: ext_evt in modes 2/3; int_evt in mode 1 or during fallback. In fallback, ext_evt is also accepted and clears fallback in the same cycle.
- FSM:
  - IDLE: taken whenever cfg_mode=0, from any state, next cycle. Leaves to WAIT when cfg_mode!=0.
  - WAIT: on an event, pulse trig_o for one cycle, set trig_src, increment trig_cnt, go to BUSY.
  - BUSY: on frame_done, go to HOLDOFF, or to WAIT if cfg_holdoff=0.
  - HOLDOFF: load cfg_holdoff on entry and decrement. Go to WAIT the cycle after the count reaches 1, so holdoff lasts exactly cfg_holdoff cycles.
- Any event outside WAIT, including IDLE-exit and transition cycles, increments missed_cnt. Simultaneous frame_done and event in BUSY counts as missed.
- Fallback (mode 3 only):
  - Timeout counter reloads cfg_timeout on every ext_evt and decrements otherwise.
  - At 0 it sets fallback=1 and stops.
  - cfg_timeout=0 disables fallback.
  - fallback clears immediately when cfg_mode!=3.
- Non-zero mode changes leave FSM state untouched; the new source applies from the next cycle.
- Counters saturate at all-ones. cnt_clr takes priority over an increment in the same cycle.
- Config inputs are quasi-static and sampled every cycle.

Test Plan:
- Mode 2, cfg_holdoff=0; EXT_TRIG_B low at edge 10, held 20 cycles -> one trig_o after edge 13, trig_src=0, trig_cnt=1, busy=1 until frame_done.
- Mode 1, cfg_period=100, frame_done 5 cycles after each trig_o, holdoff=10 -> trig_o every 100 cycles, missed_cnt=0. Repeat with frame_done at 150 cycles -> every other event missed, missed_cnt increments once per 200 cycles.
- Mode 3, cfg_timeout=1000, cfg_period=50, pin idle -> fallback=1 at cycle 1000, internal trig_o every 50. Then one EXT_TRIG_B edge -> fallback=0, that edge triggers if in WAIT, no further internal triggers.
- Holdoff=3: event on the last HOLDOFF cycle -> missed. Event one cycle later -> trig_o.
- cfg_mode->0 during BUSY -> IDLE next cycle, busy=0, later events ignored and not counted. Assert sys_rst_i mid-frame -> all outputs 0 immediately.
- Force trig_cnt to 0xFFFF -> stays 0xFFFF. cnt_clr coincident with a trigger -> trig_cnt=0.

Source files
------------

// File: rtl/trig_sequencer_if.sv
// Trigger sequencer bus: external pin, configuration, frame handshake
// and status outputs. Clock and reset stay outside as plain ports.
interface trig_sequencer_if #(
    parameter int PERIOD_W = 26,
    parameter int HOLD_W   = 16,
    parameter int CNT_W    = 16
);
    logic                EXT_TRIG_B;
    logic [1:0]          cfg_mode;
    logic [PERIOD_W-1:0] cfg_period;
    logic [HOLD_W-1:0]   cfg_holdoff;
    logic [PERIOD_W-1:0] cfg_timeout;
    logic                frame_done;
    logic                cnt_clr;
    logic                trig_o;
    logic                trig_src;
    logic                busy;
    logic                fallback;
    logic [CNT_W-1:0]    trig_cnt;
    logic [CNT_W-1:0]    missed_cnt;

    modport master (
        output EXT_TRIG_B,
        output cfg_mode,
        output cfg_period,
        output cfg_holdoff,
        output cfg_timeout,
        output frame_done,
        output cnt_clr,
        input  trig_o,
        input  trig_src,
        input  busy,
        input  fallback,
        input  trig_cnt,
        input  missed_cnt
    );

    modport slave (
        input  EXT_TRIG_B,
        input  cfg_mode,
        input  cfg_period,
        input  cfg_holdoff,
        input  cfg_timeout,
        input  frame_done,
        input  cnt_clr,
        output trig_o,
        output trig_src,
        output busy,
        output fallback,
        output trig_cnt,
        output missed_cnt
    );
endinterface

// File: rtl/trig_sequencer.sv
// Trigger scheduler: external pin, internal timer or external with
// internal fallback; one frame in flight plus holdoff; trigger counters.
module trig_sequencer #(
    parameter int PERIOD_W = 26,
    parameter int HOLD_W   = 16,
    parameter int CNT_W    = 16
) (
    input logic             sys_clk_i,
    input logic             sys_rst_i,
    trig_sequencer_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_BUSY,
        S_HOLDOFF
    } state_t;

    localparam logic [PERIOD_W-1:0] P_ONE = PERIOD_W'(1);
    localparam logic [HOLD_W-1:0]   H_ONE = HOLD_W'(1);
    localparam logic [CNT_W-1:0]    C_ONE = CNT_W'(1);

    state_t state;
    state_t nxt;

    logic                s1;
    logic                s2;
    logic                s3;
    logic                ext_evt;
    logic [PERIOD_W-1:0] tmr;
    logic [PERIOD_W-1:0] tcnt;
    logic [HOLD_W-1:0]   hcnt;
    logic                int_src;
    logic                int_src_q;
    logic                int_evt;
    logic                fb_q;
    logic                fb;
    logic                m_int;
    logic                m_ext;
    logic                m_fb;
    logic                evt;
    logic                src_int;
    logic                trig_d;
    logic                miss_d;
    logic                pulse_q;
    logic                src_q;
    logic [CNT_W-1:0]    trig_q;
    logic [CNT_W-1:0]    miss_q;

    assign m_int = (bus.cfg_mode == 2'd1);
    assign m_ext = bus.cfg_mode[1];
    assign m_fb  = (bus.cfg_mode == 2'd3);

    // Fallback drops combinationally as soon as mode 3 is left.
    assign fb      = fb_q & m_fb;
    assign int_src = m_int | fb;
    assign int_evt = int_src & int_src_q & (tmr == '0)
                   & (bus.cfg_period != '0);
    assign evt     = (m_ext & ext_evt) | int_evt;
    assign src_int = ~(m_ext & ext_evt);

    // Pin synchronizer; registering the edge keeps the pin-to-trigger
    // latency at three clocks after the first low sample.
    always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
        if (sys_rst_i) begin
            s1      <= 1'b1;
            s2      <= 1'b1;
            s3      <= 1'b1;
            ext_evt <= 1'b0;
        end else begin
            s1      <= bus.EXT_TRIG_B;
            s2      <= s1;
            s3      <= s2;
            ext_evt <= s3 & ~s2;
        end
    end

    always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
        if (sys_rst_i) begin
            tmr       <= bus.cfg_period - P_ONE;
            int_src_q <= 1'b0;
        end else begin
            int_src_q <= int_src;
            if (int_src) begin
                if (!int_src_q || tmr == '0) begin
                    tmr <= bus.cfg_period - P_ONE;
                end else begin
                    tmr <= tmr - P_ONE;
                end
            end
        end
    end

    always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
        if (sys_rst_i) begin
            tcnt <= bus.cfg_timeout;
            fb_q <= 1'b0;
        end else if (!m_fb || ext_evt) begin
            tcnt <= bus.cfg_timeout;
            fb_q <= 1'b0;
        end else if (tcnt != '0) begin
            tcnt <= tcnt - P_ONE;
            if (tcnt == P_ONE) begin
                fb_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
        if (sys_rst_i) begin
            state <= S_IDLE;
        end else begin
            state <= nxt;
        end
    end

    always_comb begin
        nxt    = state;
        trig_d = 1'b0;
        miss_d = 1'b0;
        if (bus.cfg_mode == 2'd0) begin
            nxt = S_IDLE;
        end else begin
            miss_d = evt & (state != S_WAIT);
            unique case (state)
                S_IDLE: nxt = S_WAIT;
                S_WAIT: begin
                    if (evt) begin
                        trig_d = 1'b1;
                        nxt    = S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (bus.frame_done) begin
                        nxt = (bus.cfg_holdoff == '0) ? S_WAIT : S_HOLDOFF;
                    end
                end
                S_HOLDOFF: begin
                    if (hcnt <= H_ONE) begin
                        nxt = S_WAIT;
                    end
                end
                default: nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
        if (sys_rst_i) begin
            hcnt <= '0;
        end else if (state == S_BUSY && nxt == S_HOLDOFF) begin
            hcnt <= bus.cfg_holdoff;
        end else if (state == S_HOLDOFF && hcnt != '0) begin
            hcnt <= hcnt - H_ONE;
        end
    end

    always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
        if (sys_rst_i) begin
            pulse_q <= 1'b0;
            src_q   <= 1'b0;
        end else begin
            pulse_q <= trig_d;
            if (trig_d) begin
                src_q <= src_int;
            end
        end
    end

    always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
        if (sys_rst_i) begin
            trig_q <= '0;
            miss_q <= '0;
        end else if (bus.cnt_clr) begin
            trig_q <= '0;
            miss_q <= '0;
        end else begin
            if (trig_d && !(&trig_q)) begin
                trig_q <= trig_q + C_ONE;
            end
            if (miss_d && !(&miss_q)) begin
                miss_q <= miss_q + C_ONE;
            end
        end
    end

    assign bus.trig_o     = pulse_q;
    assign bus.trig_src   = src_q;
    assign bus.busy       = (state == S_BUSY) || (state == S_HOLDOFF);
    assign bus.fallback   = fb;
    assign bus.trig_cnt   = trig_q;
    assign bus.missed_cnt = miss_q;

endmodule

// File: tb/tb_trig_sequencer.sv
// Directed bench for trig_sequencer: per-cycle vector table plus
// hand-written sequences for timer, fallback, mode change and reset.
module tb_trig_sequencer;
    localparam int PW = 26;
    localparam int HW = 16;
    localparam int CW = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    trig_sequencer_if #(.PERIOD_W(PW), .HOLD_W(HW), .CNT_W(CW)) bus ();

    trig_sequencer #(.PERIOD_W(PW), .HOLD_W(HW), .CNT_W(CW)) dut (
        .sys_clk_i(clk),
        .sys_rst_i(rst),
        .bus(bus)
    );

    typedef struct {
        logic            ext;
        logic            fd;
        logic            clr;
        logic            trig;
        logic            busy;
        logic [CW-1:0]   tc;
        logic [CW-1:0]   mc;
    } vec_t;

    vec_t tbl[20];
    int   n_vec = 0;
    int   n_err = 0;

    function automatic vec_t mk(input logic [4:0] f, input int tc,
                                input int mc);
        vec_t r;
        r.ext  = f[4];
        r.fd   = f[3];
        r.clr  = f[2];
        r.trig = f[1];
        r.busy = f[0];
        r.tc   = CW'(tc);
        r.mc   = CW'(mc);
        return r;
    endfunction

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic ext_trig();
        bus.EXT_TRIG_B = 1'b0;
        step();
        bus.EXT_TRIG_B = 1'b1;
        step();
        step();
        step();
        check("sat trig_o", 32'(bus.trig_o), 1);
        bus.frame_done = 1'b1;
        step();
        bus.frame_done = 1'b0;
        step();
    endtask

    task automatic run_int(input int fd_dly, input int exp_tr,
                           input int exp_ms, input int exp_iv);
        int last;
        int fd_at;
        int ntr;
        bus.cfg_mode    = 2'd1;
        bus.cfg_period  = PW'(100);
        bus.cfg_holdoff = HW'(10);
        bus.cfg_timeout = '0;
        do_reset();
        last  = 0;
        fd_at = -1;
        ntr   = 0;
        for (int e = 1; e <= 1000; e++) begin
            bus.frame_done = (e == fd_at);
            step();
            if (bus.trig_o) begin
                ntr++;
                if (last == 0) check("int first", e, 101);
                else check("int gap", e - last, exp_iv);
                check("int src", 32'(bus.trig_src), 1);
                last  = e;
                fd_at = e + fd_dly;
            end
        end
        bus.frame_done = 1'b0;
        check("int ntrig", ntr, exp_tr);
        check("int trig_cnt", 32'(bus.trig_cnt), exp_tr);
        check("int missed_cnt", 32'(bus.missed_cnt), exp_ms);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   ntr;
        int   te;
        int   fd_at;
        int   fb_edge;
        int   n_int;
        int   n_ext;
        int   i1;
        int   i2;
        int   ext_edge;
        int   found;
        logic src;
        logic b34;
        logic b35;

        bus.EXT_TRIG_B  = 1'b1;
        bus.cfg_mode    = 2'd2;
        bus.cfg_period  = '0;
        bus.cfg_holdoff = HW'(3);
        bus.cfg_timeout = '0;
        bus.frame_done  = 1'b0;
        bus.cnt_clr     = 1'b0;

        tbl[0]  = mk(5'b00000, 0, 0);
        tbl[1]  = mk(5'b00000, 0, 0);
        tbl[2]  = mk(5'b00000, 0, 0);
        tbl[3]  = mk(5'b00011, 1, 0);
        tbl[4]  = mk(5'b10001, 1, 0);
        tbl[5]  = mk(5'b01001, 1, 0);
        tbl[6]  = mk(5'b00001, 1, 0);
        tbl[7]  = mk(5'b00001, 1, 0);
        tbl[8]  = mk(5'b00000, 1, 1);
        tbl[9]  = mk(5'b10000, 1, 1);
        tbl[10] = mk(5'b00000, 1, 1);
        tbl[11] = mk(5'b00000, 1, 1);
        tbl[12] = mk(5'b00000, 1, 1);
        tbl[13] = mk(5'b00011, 2, 1);
        tbl[14] = mk(5'b11001, 2, 1);
        tbl[15] = mk(5'b00001, 2, 1);
        tbl[16] = mk(5'b00001, 2, 1);
        tbl[17] = mk(5'b00000, 2, 1);
        tbl[18] = mk(5'b00111, 0, 0);
        tbl[19] = mk(5'b11001, 0, 0);

        do_reset();
        check("rst trig_o", 32'(bus.trig_o), 0);
        check("rst trig_src", 32'(bus.trig_src), 0);
        check("rst busy", 32'(bus.busy), 0);
        check("rst fallback", 32'(bus.fallback), 0);
        check("rst trig_cnt", 32'(bus.trig_cnt), 0);
        check("rst missed_cnt", 32'(bus.missed_cnt), 0);
        step();
        step();
        step();

        // Holdoff=3: event on last holdoff cycle, then one cycle later.
        for (int i = 0; i < 20; i++) begin
            bus.EXT_TRIG_B = tbl[i].ext;
            bus.frame_done = tbl[i].fd;
            bus.cnt_clr    = tbl[i].clr;
            step();
            check($sformatf("tbl%0d trig_o", i), 32'(bus.trig_o),
                  32'(tbl[i].trig));
            check($sformatf("tbl%0d busy", i), 32'(bus.busy),
                  32'(tbl[i].busy));
            check($sformatf("tbl%0d trig_cnt", i), 32'(bus.trig_cnt),
                  32'(tbl[i].tc));
            check($sformatf("tbl%0d missed_cnt", i), 32'(bus.missed_cnt),
                  32'(tbl[i].mc));
        end
        bus.EXT_TRIG_B = 1'b1;
        bus.frame_done = 1'b0;
        bus.cnt_clr    = 1'b0;

        // Mode 2, no holdoff, pin held low for 20 cycles.
        bus.cfg_mode    = 2'd2;
        bus.cfg_holdoff = '0;
        do_reset();
        ntr = 0;
        te  = 0;
        src = 1'b1;
        b34 = 1'b0;
        b35 = 1'b1;
        for (int e = 1; e <= 40; e++) begin
            bus.EXT_TRIG_B = !(e >= 10 && e <= 29);
            bus.frame_done = (e == 35);
            step();
            if (bus.trig_o) begin
                ntr++;
                te  = e;
                src = bus.trig_src;
            end
            if (e == 34) b34 = bus.busy;
            if (e == 35) b35 = bus.busy;
        end
        bus.frame_done = 1'b0;
        bus.EXT_TRIG_B = 1'b1;
        check("ext ntrig", ntr, 1);
        check("ext trig edge", te, 13);
        check("ext trig_src", 32'(src), 0);
        check("ext busy before fd", 32'(b34), 1);
        check("ext busy after fd", 32'(b35), 0);
        check("ext trig_cnt", 32'(bus.trig_cnt), 1);
        check("ext missed_cnt", 32'(bus.missed_cnt), 0);

        run_int(5, 9, 0, 100);
        run_int(150, 5, 4, 200);

        // Mode 3 fallback after 1000 quiet cycles, then a pin edge.
        bus.cfg_mode    = 2'd3;
        bus.cfg_period  = PW'(50);
        bus.cfg_timeout = PW'(1000);
        bus.cfg_holdoff = '0;
        do_reset();
        fb_edge  = 0;
        n_int    = 0;
        n_ext    = 0;
        i1       = 0;
        i2       = 0;
        ext_edge = 0;
        src      = 1'b1;
        fd_at    = -1;
        for (int e = 1; e <= 1400; e++) begin
            bus.EXT_TRIG_B = (e < 1170);
            bus.frame_done = (e == fd_at);
            step();
            if (bus.fallback && fb_edge == 0) fb_edge = e;
            if (bus.trig_o) begin
                fd_at = e + 3;
                if (e < 1170) begin
                    n_int++;
                    if (n_int == 1) i1 = e;
                    if (n_int == 2) i2 = e;
                    check("fb int src", 32'(bus.trig_src), 1);
                end else begin
                    n_ext++;
                    ext_edge = e;
                    src      = bus.trig_src;
                end
            end
        end
        bus.EXT_TRIG_B = 1'b1;
        bus.frame_done = 1'b0;
        check("fb rise edge", fb_edge, 1000);
        check("fb first int", i1, 1051);
        check("fb second int", i2, 1101);
        check("fb n_int", n_int, 3);
        check("fb n_ext", n_ext, 1);
        check("fb ext edge", ext_edge, 1173);
        check("fb ext src", 32'(src), 0);
        check("fb cleared", 32'(bus.fallback), 0);
        check("fb trig_cnt", 32'(bus.trig_cnt), 4);
        check("fb missed_cnt", 32'(bus.missed_cnt), 0);

        // Coincident event and frame_done, then mode 0 during BUSY.
        bus.cfg_mode    = 2'd1;
        bus.cfg_period  = PW'(20);
        bus.cfg_holdoff = '0;
        bus.cfg_timeout = '0;
        do_reset();
        for (int e = 1; e <= 145; e++) begin
            bus.cfg_mode   = (e >= 85) ? 2'd0 : 2'd1;
            bus.frame_done = (e == 61);
            step();
            if (e == 21) check("d trig 21", 32'(bus.trig_o), 1);
            if (e == 41) check("d miss 41", 32'(bus.missed_cnt), 1);
            if (e == 61) begin
                check("d miss 61", 32'(bus.missed_cnt), 2);
                check("d busy 61", 32'(bus.busy), 0);
                check("d trig_o 61", 32'(bus.trig_o), 0);
            end
            if (e == 81) check("d trig_cnt 81", 32'(bus.trig_cnt), 2);
            if (e == 84) check("d busy 84", 32'(bus.busy), 1);
            if (e == 85) check("d busy 85", 32'(bus.busy), 0);
        end
        bus.frame_done = 1'b0;
        check("d idle trig_cnt", 32'(bus.trig_cnt), 2);
        check("d idle missed_cnt", 32'(bus.missed_cnt), 2);
        check("d idle busy", 32'(bus.busy), 0);
        bus.cfg_mode = 2'd1;
        found = 0;
        for (int e = 0; e < 40 && found == 0; e++) begin
            step();
            if (bus.trig_o) found = e + 1;
        end
        check("d retrig delay", found, 21);
        step();
        check("d busy pre-rst", 32'(bus.busy), 1);
        #3;
        rst = 1'b1;
        #1;
        check("mid rst trig_o", 32'(bus.trig_o), 0);
        check("mid rst trig_src", 32'(bus.trig_src), 0);
        check("mid rst busy", 32'(bus.busy), 0);
        check("mid rst trig_cnt", 32'(bus.trig_cnt), 0);
        check("mid rst missed_cnt", 32'(bus.missed_cnt), 0);

        // Saturation of trig_cnt at all-ones.
        bus.cfg_mode    = 2'd2;
        bus.cfg_holdoff = '0;
        do_reset();
        step();
        step();
        step();
        force dut.trig_q = 16'hFFFE;
        #1;
        release dut.trig_q;
        ext_trig();
        check("sat first", 32'(bus.trig_cnt), 32'hFFFF);
        ext_trig();
        check("sat hold", 32'(bus.trig_cnt), 32'hFFFF);
        bus.cnt_clr = 1'b1;
        step();
        bus.cnt_clr = 1'b0;
        check("sat clr", 32'(bus.trig_cnt), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
